// File: rtl/pp_buf_pkg.sv
// Shared helpers for the pp_gearbox width converter.
//   gb_ratio : ratio of the larger to the smaller data width
//   gb_cnt_w : chunk counter width for a given ratio
//   gb_mode  : picks downsize / upsize / pass-through from the widths
package pp_buf_pkg;

  typedef enum logic [1:0] {
    GB_DOWN,
    GB_UP,
    GB_PASS
  } gb_mode_e;

  function automatic int unsigned gb_ratio(input int unsigned wi, input int unsigned wo);
    return (wi > wo) ? (wi / wo) : (wo / wi);
  endfunction

  function automatic int unsigned gb_cnt_w(input int unsigned r);
    return $clog2(r) + 1;
  endfunction

  function automatic gb_mode_e gb_mode(input int unsigned wi, input int unsigned wo);
    if (wi > wo) return GB_DOWN;
    if (wo > wi) return GB_UP;
    return GB_PASS;
  endfunction

endpackage

// File: rtl/pp_gearbox.sv
// Streaming parallel-to-parallel width converter with valid/ready on both
// sides and packet-boundary (last) propagation.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake
//   in_data[WIDTH_I-1:0] : input payload
//   in_last              : final input of a packet
//   out_valid/out_ready  : output handshake
//   out_data[WIDTH_O-1:0]: output payload
//   out_last             : final output of a packet
// Downsize emits MSB-first; upsize packs the first chunk into the MSBs and
// left-aligns/zero-pads a word cut short by in_last.
module pp_gearbox
  import pp_buf_pkg::*;
#(
  parameter int unsigned WIDTH_I = 16,
  parameter int unsigned WIDTH_O = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_I-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_O-1:0] out_data,
  output logic               out_last
);

  localparam int unsigned R    = gb_ratio(WIDTH_I, WIDTH_O);
  localparam int unsigned CW   = gb_cnt_w(R);
  localparam gb_mode_e    MODE = gb_mode(WIDTH_I, WIDTH_O);

  if (((WIDTH_I % WIDTH_O) != 0) && ((WIDTH_O % WIDTH_I) != 0)) begin : g_bad_ratio
    $error("pp_gearbox: WIDTH_I=%0d and WIDTH_O=%0d are not integer multiples", WIDTH_I, WIDTH_O);
  end

  if (MODE == GB_DOWN) begin : g_down
    logic [WIDTH_I-1:0] sreg_q;
    logic [CW-1:0]      cnt_q;
    logic               last_q;

    // Accept on the final chunk too, so consecutive words run without a bubble.
    always_comb begin
      out_valid = (cnt_q != '0);
      out_data  = sreg_q[WIDTH_I-1 -: WIDTH_O];
      out_last  = last_q & (cnt_q == CW'(1));
      in_ready  = (cnt_q == '0) | ((cnt_q == CW'(1)) & out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sreg_q <= '0;
        cnt_q  <= '0;
        last_q <= 1'b0;
      end else if (in_valid && in_ready) begin
        sreg_q <= in_data;
        cnt_q  <= CW'(R);
        last_q <= in_last;
      end else if (out_valid && out_ready) begin
        sreg_q <= sreg_q << WIDTH_O;
        cnt_q  <= cnt_q - CW'(1);
      end
    end

  end else if (MODE == GB_UP) begin : g_up
    // Gather register only needs R-1 chunks; the R-th goes straight to the word.
    localparam int unsigned GW = WIDTH_O - WIDTH_I;

    logic [GW-1:0]      g_q;
    logic [CW-1:0]      g_cnt_q;
    logic [WIDTH_O-1:0] o_data_q;
    logic               o_valid_q;
    logic               o_last_q;

    logic [WIDTH_O-1:0] word;
    logic [WIDTH_O-1:0] word_al;
    logic [CW-1:0]      cnt_nxt;
    logic               done;

    always_comb begin
      in_ready  = !o_valid_q | out_ready;
      out_valid = o_valid_q;
      out_data  = o_data_q;
      out_last  = o_last_q;
      word      = {g_q, in_data};
      cnt_nxt   = g_cnt_q + CW'(1);
      done      = (cnt_nxt == CW'(R)) | in_last;
      // Short packet tail: shift gathered chunks up to the MSBs, zeros below.
      word_al   = word << ((R - 32'(cnt_nxt)) * WIDTH_I);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        g_q       <= '0;
        g_cnt_q   <= '0;
        o_data_q  <= '0;
        o_valid_q <= 1'b0;
        o_last_q  <= 1'b0;
      end else begin
        if (o_valid_q && out_ready) begin
          o_valid_q <= 1'b0;
        end
        if (in_valid && in_ready) begin
          if (done) begin
            o_data_q  <= word_al;
            o_valid_q <= 1'b1;
            o_last_q  <= in_last;
            g_q       <= '0;
            g_cnt_q   <= '0;
          end else begin
            g_q     <= word[GW-1:0];
            g_cnt_q <= cnt_nxt;
          end
        end
      end
    end

  end else begin : g_pass
    logic [WIDTH_O-1:0] o_data_q;
    logic               o_valid_q;
    logic               o_last_q;

    always_comb begin
      in_ready  = !o_valid_q | out_ready;
      out_valid = o_valid_q;
      out_data  = o_data_q;
      out_last  = o_last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        o_data_q  <= '0;
        o_valid_q <= 1'b0;
        o_last_q  <= 1'b0;
      end else if (in_valid && in_ready) begin
        o_data_q  <= in_data;
        o_valid_q <= 1'b1;
        o_last_q  <= in_last;
      end else if (out_ready) begin
        o_valid_q <= 1'b0;
      end
    end
  end

endmodule
